fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one sync_fifo write port among NUM_REQ requesters.
Each requester presents valid/data. The block grants at most one requester per cycle and drives the FIFO write enable and data combinationally.
An optional burst hold lets a granted requester keep the port for up to MAX_BURST consecutive beats. It sits directly in front of a sync_fifo instance and uses that FIFO's o_full as back-pressure.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_arbiter.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        BURST = 2'b10
    } arb_state_t;

    // Increment with explicit wrap to zero once value reaches limit.
    function automatic int wrap_inc(input int value, input int limit);
        return (value >= limit) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// rtl/fifo_wr_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr_i
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    localparam logic [PTR_W:0] NUM_W = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0] cand;

    // One extra bit on cand so ptr+offset never overflows before the wrap compare.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr_i} + (PTR_W+1)'(off);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (!any_o && req_i[cand[PTR_W-1:0]]) begin
                any_o                     = 1'b1;
                idx_o                     = cand[PTR_W-1:0];
                grant_o[cand[PTR_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter with burst hold in front of a sync_fifo
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 2
) (
    input  logic                            i_clock,
    input  logic                            i_aresetn,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]              o_req_ready,
    input  logic                            i_fifo_full,
    output logic                            o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           o_fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]      o_grant_id,
    output logic                            o_busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               in_burst;
    logic               owner_hold;
    logic               arb_en;
    logic               grant_any;
    logic [PTR_W-1:0]   owner_next;
    logic [PTR_W-1:0]   arb_ptr;
    logic [PTR_W-1:0]   sel_idx;
    logic [CNT_W-1:0]   cnt_inc;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] grant_vec;
    logic [NUM_REQ-1:0] rr_grant;
    logic [PTR_W-1:0]   rr_idx;
    logic               rr_any;

    // Any encoding other than BURST is treated as IDLE.
    assign in_burst   = (state_q == BURST);
    assign owner_hold = in_burst && i_req_valid[owner_q];
    assign owner_next = PTR_W'(wrap_inc(int'(owner_q), NUM_REQ - 1));
    assign arb_ptr    = in_burst ? owner_next : ptr_q;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign arb_en     = i_aresetn && !i_fifo_full;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i   (i_req_valid),
        .ptr_i   (arb_ptr),
        .grant_o (rr_grant),
        .idx_o   (rr_idx),
        .any_o   (rr_any)
    );

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner_q == PTR_W'(i));
        end
    end

    assign grant_any = arb_en && (owner_hold || rr_any);
    assign sel_idx   = owner_hold ? owner_q : rr_idx;
    assign grant_vec = arb_en ? (owner_hold ? owner_oh : rr_grant) : '0;

    always_comb begin
        o_fifo_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vec[i]) begin
                o_fifo_data = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_req_ready  = grant_vec;
    assign o_fifo_wr_en = |(grant_vec & i_req_valid);
    assign o_grant_id   = grant_any ? sel_idx : '0;
    assign o_busy       = in_burst;

    // A dropped owner releases in the same cycle; rr_arbiter already scans from owner+1.
    always_comb begin
        state_d = in_burst ? BURST : IDLE;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (o_fifo_wr_en) begin
            if (owner_hold) begin
                if (cnt_inc == MAX_C) begin
                    state_d = IDLE;
                    ptr_d   = owner_next;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end else if (MAX_BURST == 1) begin
                state_d = IDLE;
                ptr_d   = PTR_W'(wrap_inc(int'(rr_idx), NUM_REQ - 1));
            end else begin
                state_d = BURST;
                owner_d = rr_idx;
                cnt_d   = CNT_W'(1);
            end
        end else if (in_burst && !i_fifo_full && !i_req_valid[owner_q]) begin
            state_d = IDLE;
            ptr_d   = owner_next;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // a: NUM_REQ=4 MAX_BURST=1, b: NUM_REQ=4 MAX_BURST=2, c: NUM_REQ=3 MAX_BURST=1
    logic [3:0]  va, vb, rdya, rdyb;
    logic [2:0]  vc, rdyc;
    logic [31:0] da, db;
    logic [23:0] dc;
    logic        fa, wea, web, wec, busya, busyb, busyc;
    logic [7:0]  doa, dob, doc;
    logic [1:0]  gida, gidb, gidc;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut_a (
        .i_clock(clk), .i_aresetn(rst_n), .i_req_valid(va), .i_req_data(da),
        .o_req_ready(rdya), .i_fifo_full(fa), .o_fifo_wr_en(wea), .o_fifo_data(doa),
        .o_grant_id(gida), .o_busy(busya));

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(2)) dut_b (
        .i_clock(clk), .i_aresetn(rst_n), .i_req_valid(vb), .i_req_data(db),
        .o_req_ready(rdyb), .i_fifo_full(1'b0), .o_fifo_wr_en(web), .o_fifo_data(dob),
        .o_grant_id(gidb), .o_busy(busyb));

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut_c (
        .i_clock(clk), .i_aresetn(rst_n), .i_req_valid(vc), .i_req_data(dc),
        .o_req_ready(rdyc), .i_fifo_full(1'b0), .o_fifo_wr_en(wec), .o_fifo_data(doc),
        .o_grant_id(gidc), .o_busy(busyc));

    // Depth-4 sync_fifo model behind dut_a, active only during the full test.
    logic       fen, pop;
    logic [7:0] fmem [16];
    logic [3:0] wp = '0;
    logic [3:0] rp = '0;
    logic [7:0] rd = '0;

    always @(posedge clk) begin
        if (fen && wea) begin
            fmem[wp] <= doa;
            wp       <= wp + 4'd1;
        end
        if (pop) begin
            rd <= fmem[rp];
            rp <= rp + 4'd1;
        end
    end
    assign fa = fen && ((wp - rp) == 4'd4);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int exp_a [6] = '{0, 1, 2, 3, 0, 1};
    int exp_b [6] = '{0, 0, 2, 2, 0, 0};
    int bsy_b [6] = '{0, 1, 0, 1, 0, 1};
    int exp_c [5] = '{0, 1, 2, 0, 1};
    int drp_g [4] = '{1, 3, 3, 0};
    int drp_y [4] = '{0, 1, 1, 0};
    logic [3:0] drp_v [4] = '{4'b0010, 4'b1000, 4'b1000, 4'b1111};

    initial begin
        rst_n = 1'b0;
        va = '0; vc = '0; da = '0; dc = '0; db = '0;
        vb = 4'hF;
        fen = 1'b0; pop = 1'b0;
        #1;
        check("rst_ready", 32'(rdyb), 32'h0);
        check("rst_wr_en", 32'(web), 32'h0);
        check("rst_gid", 32'(gidb), 32'h0);
        repeat (2) @(negedge clk);
        vb = '0;
        rst_n = 1'b1;
        #1;
        check("idle_wr_en", 32'(web), 32'h0);

        // Pure round-robin, all requesters valid
        @(negedge clk);
        va = 4'hF;
        da = 32'h33221100;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr4_gid", 32'(gida), 32'(exp_a[k]));
            check("rr4_wr", 32'(wea), 32'h1);
            check("rr4_data", 32'(doa), 32'(exp_a[k] * 8'h11));
            check("rr4_ready", 32'(rdya), 32'(1 << exp_a[k]));
            @(negedge clk);
        end
        va = '0;

        // Burst of two, requesters 0 and 2
        vb = 4'b0101;
        db = 32'hB3B2B1B0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("b2_gid", 32'(gidb), 32'(exp_b[k]));
            check("b2_busy", 32'(busyb), 32'(bsy_b[k]));
            check("b2_data", 32'(dob), 32'(8'hB0 + exp_b[k]));
            @(negedge clk);
        end

        // Owner drops mid-burst: req3 wins the same cycle, then ptr returns to 0
        for (int k = 0; k < 4; k++) begin
            vb = drp_v[k];
            #1;
            check("drop_gid", 32'(gidb), 32'(drp_g[k]));
            check("drop_busy", 32'(busyb), 32'(drp_y[k]));
            check("drop_wr", 32'(web), 32'h1);
            @(negedge clk);
        end
        vb = '0;

        // Three requesters, ptr wraps 2 -> 0
        vc = 3'b111;
        dc = 24'hC2C1C0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr3_gid", 32'(gidc), 32'(exp_c[k]));
            check("rr3_data", 32'(doc), 32'(8'hC0 + exp_c[k]));
            @(negedge clk);
        end
        vc = '0;

        // FIFO full back-pressure
        fen = 1'b1;
        va = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            da = 32'(8'hA0 + k);
            #1;
            check("full_pre_wr", 32'(wea), 32'h1);
            check("full_pre_data", 32'(doa), 32'(8'hA0 + k));
            @(negedge clk);
        end
        da = 32'hA4;
        #1;
        check("full_flag", 32'(fa), 32'h1);
        check("full_ready", 32'(rdya), 32'h0);
        check("full_wr", 32'(wea), 32'h0);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        #1;
        check("pop_wr", 32'(wea), 32'h1);
        check("pop_data", 32'(doa), 32'hA4);
        check("pop_ready", 32'(rdya), 32'h1);
        @(negedge clk);
        da = 32'hA5;
        #1;
        check("refull_wr", 32'(wea), 32'h0);
        check("readback0", 32'(rd), 32'hA0);
        for (int i = 1; i < 5; i++) begin
            check("readback", 32'(fmem[4'(i)]), 32'(8'hA0 + i));
        end
        va = '0;
        fen = 1'b0;
        @(negedge clk);

        // Reset in the middle of a burst
        vb = 4'hF;
        db = 32'hB3B2B1B0;
        @(negedge clk);
        #1;
        check("mid_busy", 32'(busyb), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mrst_ready", 32'(rdyb), 32'h0);
        check("mrst_wr", 32'(web), 32'h0);
        check("mrst_data", 32'(dob), 32'h0);
        check("mrst_gid", 32'(gidb), 32'h0);
        check("mrst_busy", 32'(busyb), 32'h0);
        @(negedge clk);
        vb = '0;
        rst_n = 1'b1;
        #1;
        check("post_wr", 32'(web), 32'h0);
        check("post_gid", 32'(gidb), 32'h0);
        check("post_busy", 32'(busyb), 32'h0);
        @(negedge clk);
        vb = 4'b1110;
        #1;
        check("post_ptr_gid", 32'(gidb), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
